// File: rtl/seq_comparator_ctrl_if.sv
// Request/result bundle between a compare requester and seq_comparator_ctrl.
// The requester drives start and the operands; the sequencer returns status and result flags.
interface seq_comparator_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  modport master (
    output start, a, b,
    input  busy, done, a_gt_b, a_eq_b, a_lt_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_gt_b, a_eq_b, a_lt_b
  );
endinterface

// File: rtl/seq_comparator_ctrl.sv
// Multi-cycle unsigned magnitude compare, MSB-first, two bits per cycle,
// reusing one 2-bit greater/equal/less slice for every slice pair.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

// state   | meaning
// IDLE    | waiting for start; result flags hold the last outcome
// COMPARE | examining slice idx of the captured operands
// DONE    | one-cycle done pulse with the final flags
module seq_comparator_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_comparator_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 2;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("seq_comparator_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             res_gt_q, res_gt_d, res_lt_q, res_lt_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic             slc_gt, slc_eq, slc_lt;
  logic             found, hit_gt, hit_lt;

  assign a_sh = a_q >> {idx_q, 1'b0};
  assign b_sh = b_q >> {idx_q, 1'b0};

  cmp2_slice u_slice (
    .a  (a_sh[1:0]),
    .b  (b_sh[1:0]),
    .gt (slc_gt),
    .eq (slc_eq),
    .lt (slc_lt)
  );

  // Only the most significant unequal slice decides; later slices cannot override it.
  assign found  = res_gt_q | res_lt_q;
  assign hit_gt = res_gt_q | (~found & slc_gt);
  assign hit_lt = res_lt_q | (~found & slc_lt);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    res_gt_d = res_gt_q;
    res_lt_d = res_lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          idx_d    = IDX_LAST;
          res_gt_d = 1'b0;
          res_lt_d = 1'b0;
          gt_d     = 1'b0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        res_gt_d = hit_gt;
        res_lt_d = hit_lt;
        if ((idx_q == '0) || ((EARLY_EXIT != 0) && !slc_eq)) begin
          gt_d    = hit_gt;
          lt_d    = hit_lt;
          eq_d    = ~(hit_gt | hit_lt);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      res_gt_q <= 1'b0;
      res_lt_q <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      res_gt_q <= res_gt_d;
      res_lt_q <= res_lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.a_gt_b = gt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_lt_b = lt_q;
endmodule

// File: tb/tb_seq_comparator_ctrl.sv
// Directed bench for seq_comparator_ctrl: one early-exit and one fixed-latency
// instance share the same stimulus and are checked against hand-computed results.
module tb_seq_comparator_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;

  int checks = 0;
  int errors = 0;

  seq_comparator_ctrl_if #(.WIDTH(8)) if_ee ();
  seq_comparator_ctrl_if #(.WIDTH(8)) if_fl ();

  assign if_ee.start = start;
  assign if_ee.a     = a;
  assign if_ee.b     = b;
  assign if_fl.start = start;
  assign if_fl.a     = a;
  assign if_fl.b     = b;

  seq_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_ee (.clk(clk), .rst(rst), .bus(if_ee));
  seq_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_fl (.clk(clk), .rst(rst), .bus(if_fl));

  always #5 clk = ~clk;

  // per-run observations
  int         lat_ee, lat_fl, done_ee, done_fl, busy_ee, busy_fl;
  logic [2:0] flg_ee, flg_fl;

  // at-most-one-flag monitor
  logic inv_en = 1'b0;
  int   inv_viol = 0;
  always @(negedge clk) begin
    if (inv_en) begin
      if ($countones({if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b}) > 1) inv_viol++;
      if ($countones({if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b}) > 1) inv_viol++;
    end
  end

  task automatic sample(input int cyc);
    if (if_ee.busy) busy_ee++;
    if (if_fl.busy) busy_fl++;
    if (if_ee.done) begin
      done_ee++;
      if (lat_ee == 0) begin
        lat_ee = cyc;
        flg_ee = {if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b};
      end
    end
    if (if_fl.done) begin
      done_fl++;
      if (lat_fl == 0) begin
        lat_fl = cyc;
        flg_fl = {if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b};
      end
    end
  endtask

  // Issue one start; optionally re-assert start during cycle inj_cyc. 12-cycle observation window.
  task automatic run(input logic [7:0] ra, input logic [7:0] rb,
                     input int inj_cyc, input logic [7:0] ia, input logic [7:0] ib);
    lat_ee = 0; lat_fl = 0; done_ee = 0; done_fl = 0; busy_ee = 0; busy_fl = 0;
    flg_ee = 3'b000; flg_fl = 3'b000;
    @(negedge clk);
    start = 1'b1; a = ra; b = rb;
    @(posedge clk); #1;
    start = 1'b0; a = ~ra; b = ra;
    sample(1);
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      sample(cyc);
      if (cyc == inj_cyc) begin
        start = 1'b1; a = ia; b = ib;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h54;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({if_ee.busy, if_ee.done, if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ee got %b exp 00000", {if_ee.busy, if_ee.done, if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b});
      end
      checks++;
      if ({if_fl.busy, if_fl.done, if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b} !== 5'b0) begin
        errors++;
        $display("FAIL reset_fl got %b exp 00000", {if_fl.busy, if_fl.done, if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b});
      end
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({if_ee.busy, if_fl.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_start busy got %b exp 00", {if_ee.busy, if_fl.busy});
    end
    inv_en = 1'b1;
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] le;
    logic [3:0] lf;
    logic [2:0] f;  // {gt, eq, lt}
  } vec_t;

  task automatic test_vectors();
    vec_t vecs [0:5];
    vecs[0] = '{8'hA5, 8'hA5, 4'd5, 4'd5, 3'b010};
    vecs[1] = '{8'h80, 8'h7F, 4'd2, 4'd5, 3'b100};
    vecs[2] = '{8'h12, 8'h13, 4'd5, 4'd5, 3'b001};
    vecs[3] = '{8'h00, 8'hFF, 4'd2, 4'd5, 3'b001};
    vecs[4] = '{8'hFF, 8'h00, 4'd2, 4'd5, 3'b100};
    vecs[5] = '{8'h34, 8'h24, 4'd3, 4'd5, 3'b100};
    for (int v = 0; v < 6; v++) begin
      run(vecs[v].a, vecs[v].b, 0, 8'h00, 8'h00);
      checks++;
      if (lat_ee !== int'(vecs[v].le)) begin
        errors++; $display("FAIL vec%0d lat_ee got %0d exp %0d", v, lat_ee, vecs[v].le);
      end
      checks++;
      if (lat_fl !== int'(vecs[v].lf)) begin
        errors++; $display("FAIL vec%0d lat_fl got %0d exp %0d", v, lat_fl, vecs[v].lf);
      end
      checks++;
      if (flg_ee !== vecs[v].f) begin
        errors++; $display("FAIL vec%0d flags_ee got %b exp %b", v, flg_ee, vecs[v].f);
      end
      checks++;
      if (flg_fl !== vecs[v].f) begin
        errors++; $display("FAIL vec%0d flags_fl got %b exp %b", v, flg_fl, vecs[v].f);
      end
      checks++;
      if ((done_ee !== 1) || (done_fl !== 1)) begin
        errors++; $display("FAIL vec%0d done_pulses got %0d/%0d exp 1/1", v, done_ee, done_fl);
      end
      checks++;
      if ((busy_ee !== int'(vecs[v].le)) || (busy_fl !== int'(vecs[v].lf))) begin
        errors++; $display("FAIL vec%0d busy_cycles got %0d/%0d exp %0d/%0d", v, busy_ee, busy_fl, vecs[v].le, vecs[v].lf);
      end
    end
  endtask

  task automatic test_flag_hold();
    run(8'hA5, 8'hA5, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({if_ee.busy, if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b, if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b} !== 7'b0_010_010) begin
        errors++;
        $display("FAIL flag_hold got %b exp 0010010",
                 {if_ee.busy, if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b, if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b});
      end
    end
  endtask

  task automatic test_busy_protect();
    run(8'h40, 8'h41, 2, 8'hFF, 8'h00);
    checks++;
    if ({flg_ee, flg_fl} !== 6'b001_001) begin
      errors++; $display("FAIL busy_protect flags got %b exp 001001", {flg_ee, flg_fl});
    end
    checks++;
    if ((lat_ee !== 5) || (lat_fl !== 5) || (done_ee !== 1) || (done_fl !== 1)) begin
      errors++; $display("FAIL busy_protect lat/done got %0d/%0d %0d/%0d exp 5/5 1/1", lat_ee, lat_fl, done_ee, done_fl);
    end
  endtask

  task automatic test_back_to_back();
    // start re-asserted during the early-exit instance's DONE cycle must be dropped
    run(8'h80, 8'h7F, 2, 8'h00, 8'hFF);
    checks++;
    if ((done_ee !== 1) || (busy_ee !== 2)) begin
      errors++; $display("FAIL back_to_back done/busy got %0d/%0d exp 1/2", done_ee, busy_ee);
    end
    checks++;
    if ({if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b} !== 3'b100) begin
      errors++; $display("FAIL back_to_back held_flags got %b exp 100", {if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b});
    end
  endtask

  task automatic test_reset_mid_op();
    int dn;
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({if_ee.busy, if_ee.done, if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b,
         if_fl.busy, if_fl.done, if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_op outputs got %b/%b exp 00000/00000",
               {if_ee.busy, if_ee.done, if_ee.a_gt_b, if_ee.a_eq_b, if_ee.a_lt_b},
               {if_fl.busy, if_fl.done, if_fl.a_gt_b, if_fl.a_eq_b, if_fl.a_lt_b});
    end
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if_ee.done || if_fl.done || if_ee.busy || if_fl.busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL reset_mid_op stray_activity got %0d exp 0", dn);
    end
    run(8'h03, 8'h02, 0, 8'h00, 8'h00);
    checks++;
    if ((lat_ee !== 5) || (lat_fl !== 5) || ({flg_ee, flg_fl} !== 6'b100_100)) begin
      errors++; $display("FAIL reset_mid_op restart got %0d/%0d %b exp 5/5 100100", lat_ee, lat_fl, {flg_ee, flg_fl});
    end
  endtask

  task automatic test_invariant();
    checks++;
    if (inv_viol !== 0) begin
      errors++; $display("FAIL one_hot_flags violations got %0d exp 0", inv_viol);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
    test_vectors();
    test_flag_hold();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_op();
    test_invariant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_comparator_ctrl.md
Name: seq_comparator_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands MSB-first, two bits per cycle.
- Each cycle it evaluates one 2-bit slice pair with the team's 2-bit greater/equal/less slice logic, instantiated once and time-shared across all slices.
- Uses a start/busy/done handshake.
- Sits between a requester that holds operands and the shared 2-bit compare datapath. It trades area for latency on wide compares.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. Other values are illegal; elaboration stops with an error.
- EARLY_EXIT, 1, 1 = finish as soon as a slice pair differs; 0 = always scan all WIDTH/2 slices (fixed latency).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepted start.
- b  input  WIDTH  operand B. Captured on the accepted start.
- busy  output  1  high while in COMPARE or DONE
- done  output  1  one-cycle pulse when result flags become valid
- a_gt_b  output  1  A > B result flag
- a_eq_b  output  1  A == B result flag
- a_lt_b  output  1  A < B result flag

Behaviour:
- Reset: one clk edge with rst=1 forces:
  - state to IDLE;
  - busy, done, a_gt_b, a_eq_b and a_lt_b to 0;
  - operand registers and slice index to 0.
- rst overrides all other inputs, including start in the same cycle.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 latches a and b into internal registers.
  - Slice index idx is set to WIDTH/2-1.
  - All three flags are cleared to 0 and the state moves to COMPARE.
  - start=0 keeps the state in IDLE with flags held.
- COMPARE:
  - Each cycle the slice logic compares A_reg[2*idx+1:2*idx] against B_reg[2*idx+1:2*idx].
  - Slice gt: set an internal gt/lt result register, go to DONE if EARLY_EXIT=1.
  - Slice lt: same as slice gt, with the lt result recorded.
  - With EARLY_EXIT=0, only the first (most significant) unequal slice is recorded. Later slices do not change the result.
  - Slice eq with idx>0: idx decrements and the state stays in COMPARE.
  - idx==0: go to DONE. If no slice differed, the result is eq.
- DONE:
  - done=1 for exactly one cycle.
  - The recorded result drives exactly one of a_gt_b / a_eq_b / a_lt_b high on the same cycle as done.
  - Next state is IDLE.
- Flag hold: the result flags remain stable in IDLE until the next accepted start clears them.
- busy timing: high from the cycle after the accepted start through the DONE cycle inclusive. Low in IDLE.
- Latency, counted from the start-sampling edge to done high:
  - K+1 cycles, where K is the number of slices examined.
  - K = WIDTH/2 for equal operands or when EARLY_EXIT=0.
  - K = position of the first differing slice from the MSB (1..WIDTH/2) otherwise.
- Busy handling:
  - start while busy=1 is ignored, not queued.
  - Changes on a/b after acceptance have no effect.
- Back-to-back requests: start asserted in the DONE cycle is ignored. It must be re-asserted in IDLE, so the minimum request spacing is K+2 cycles.
- Reset mid-operation: rst during COMPARE or DONE aborts the compare and returns to the reset state. No done pulse is emitted.
- Invariant: at most one result flag high at any time. After any done, exactly one is high.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> busy=done=gt=eq=lt=0, no compare started.
- Equal operands: WIDTH=8, a=0xA5, b=0xA5, start pulse -> busy high for 5 cycles, done at cycle 5 after start, a_eq_b=1, gt=lt=0, flags held in IDLE afterwards.
- MSB slice differs: EARLY_EXIT=1, a=0x80, b=0x7F -> done at cycle 2, a_gt_b=1. Repeat with EARLY_EXIT=0 -> done at cycle 5, a_gt_b=1.
- LSB slice differs: a=0x12, b=0x13 -> done at cycle 5, a_lt_b=1. Boundary values a=0x00, b=0xFF -> a_lt_b=1, and a=0xFF, b=0x00 -> a_gt_b=1.
- Busy protection: start with a=0x40, b=0x41; at cycle 2 assert start with a=0xFF, b=0x00 -> second start ignored, first compare completes with a_lt_b=1, only one done pulse.
- Reset during operation: start a=0x01, b=0x01, rst=1 at cycle 2 -> next cycle all outputs 0, no done. A following start with a=0x03, b=0x02 -> a_gt_b=1 at cycle 5.
